// File: rtl/hwregs_bridge_pkg.sv
// Shared types and constants for the CPU-to-hardware-register bridge.
// Latency: none (declarations only).
// Backpressure: n/a.
package hwregs_bridge_pkg;

  localparam logic [15:0] HWREGS_BASE = 16'hE000;
  localparam logic [31:0] ERR_DATA    = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [8:0]  tag;
  } req_t;

  typedef struct packed {
    logic [8:0]  tag;
    logic [31:0] rdata;
    logic        rerror;
  } rsp_t;

  // A request targets the register block only inside its 64 KiB window and word aligned.
  function automatic logic addr_hits(input logic [31:0] address);
    return (address[31:16] == HWREGS_BASE) && (address[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/hwregs_bridge_if.sv
// CPU request/response and register-block strobe/response signals of the bridge.
// Latency: none (wiring only).
// Backpressure: cpu_ready on requests, cpu_rready on responses; register side has none.
interface hwregs_bridge_if;

  logic        cpu_request;
  logic        cpu_ready;
  logic        cpu_write;
  logic [31:0] cpu_address;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_wdata;
  logic [8:0]  cpu_tag;

  logic        cpu_rvalid;
  logic        cpu_rready;
  logic [8:0]  cpu_rtag;
  logic [31:0] cpu_rdata;
  logic        cpu_rerror;

  logic        hwregs_request;
  logic        hwregs_write;
  logic [15:0] hwregs_address;
  logic [3:0]  hwregs_wmask;
  logic [31:0] hwregs_wdata;
  logic        hwregs_rvalid;
  logic [8:0]  hwregs_rtag;
  logic [31:0] hwregs_rdata;

  // Bridge view.
  modport slave (
    input  cpu_request, cpu_write, cpu_address, cpu_wmask, cpu_wdata, cpu_tag, cpu_rready,
           hwregs_rvalid, hwregs_rtag, hwregs_rdata,
    output cpu_ready, cpu_rvalid, cpu_rtag, cpu_rdata, cpu_rerror,
           hwregs_request, hwregs_write, hwregs_address, hwregs_wmask, hwregs_wdata
  );

  // Environment view: CPU plus register block.
  modport master (
    output cpu_request, cpu_write, cpu_address, cpu_wmask, cpu_wdata, cpu_tag, cpu_rready,
           hwregs_rvalid, hwregs_rtag, hwregs_rdata,
    input  cpu_ready, cpu_rvalid, cpu_rtag, cpu_rdata, cpu_rerror,
           hwregs_request, hwregs_write, hwregs_address, hwregs_wmask, hwregs_wdata
  );

endinterface

// File: rtl/hwregs_bridge_sync_fifo.sv
// Generic synchronous FIFO, power-of-two depth, extra pointer bit for full/empty.
// Latency: pushed data visible at the head the cycle after the push; no bypass.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointers wrap naturally; the top bit separates full from empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; consumers qualify the head with !empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hwregs_bridge.sv
// CPU to hardware-register bridge: queues requests, decodes, issues strobes, returns read data in order.
// Latency: strobe 1 cycle after acceptance; read data 3 cycles with a 1-cycle register block; decode-error read 2 cycles.
// Backpressure: cpu_ready follows request-queue space; reads wait for a response credit; cpu_rready holds responses.
module hwregs_bridge
  import hwregs_bridge_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  hwregs_bridge_if.slave bus
);

  localparam int              CW         = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW-1:0]   CREDIT_MAX = CW'(RSP_DEPTH);

  req_t          req_in;
  req_t          req_head;
  logic          req_full;
  logic          req_empty;
  logic          req_pop;
  rsp_t          rsp_in;
  rsp_t          rsp_head;
  logic          rsp_full;
  logic          rsp_empty;
  logic          rsp_push;
  logic          rsp_pop;
  logic          ready_en;
  logic [CW-1:0] credits;
  logic [CW-1:0] hw_out;
  rsp_t          pend;
  logic          pend_vld;
  logic          head_ok;
  logic          issue_strobe;
  logic          issue_err;
  logic          take_credit;
  logic          hw_push;
  logic          hw_rd_issue;

  assign req_in = '{write:   bus.cpu_write,
                    address: bus.cpu_address,
                    wmask:   bus.cpu_wmask,
                    wdata:   bus.cpu_wdata,
                    tag:     bus.cpu_tag};

  // Readiness is gated by a flop so it rises only on the first clock after reset.
  assign bus.cpu_ready = ready_en && !req_full;

  sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (bus.cpu_request && bus.cpu_ready),
    .push_data (req_in),
    .pop       (req_pop),
    .pop_data  (req_head),
    .full      (req_full),
    .empty     (req_empty)
  );

  // Head decode and issue decision; one entry per cycle, nothing while an error entry is parked.
  always_comb begin
    req_pop      = 1'b0;
    issue_strobe = 1'b0;
    issue_err    = 1'b0;
    take_credit  = 1'b0;
    head_ok      = addr_hits(req_head.address);
    if (!req_empty && !pend_vld) begin
      if (req_head.write) begin
        req_pop      = 1'b1;
        issue_strobe = head_ok;
      end else if (credits < CREDIT_MAX) begin
        req_pop      = 1'b1;
        take_credit  = 1'b1;
        issue_strobe = head_ok;
        issue_err    = !head_ok;
      end
    end
  end

  assign hw_rd_issue = issue_strobe && !req_head.write;
  // Responses with no read in flight at the register block are dropped.
  assign hw_push     = bus.hwregs_rvalid && (hw_out != '0);
  assign rsp_push    = hw_push || pend_vld;
  assign rsp_in      = hw_push ? '{tag: bus.hwregs_rtag, rdata: bus.hwregs_rdata, rerror: 1'b0} : pend;
  assign rsp_pop     = bus.cpu_rvalid && bus.cpu_rready;

  sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rsp_push),
    .push_data (rsp_in),
    .pop       (rsp_pop),
    .pop_data  (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty)
  );

  assign bus.cpu_rvalid = !rsp_empty;
  assign bus.cpu_rtag   = rsp_empty ? '0 : rsp_head.tag;
  assign bus.cpu_rdata  = rsp_empty ? '0 : rsp_head.rdata;
  assign bus.cpu_rerror = rsp_empty ? 1'b0 : rsp_head.rerror;

  // Ready enable, response credits and register-block reads in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_en <= 1'b0;
      credits  <= '0;
      hw_out   <= '0;
    end else begin
      ready_en <= 1'b1;
      case ({take_credit, rsp_pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
      case ({hw_rd_issue, hw_push})
        2'b10:   hw_out <= hw_out + 1'b1;
        2'b01:   hw_out <= hw_out - 1'b1;
        default: hw_out <= hw_out;
      endcase
    end
  end

  // Error entries always pass through here; they wait one more cycle if a register response wins the queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend     <= '0;
    end else if (issue_err) begin
      pend_vld <= 1'b1;
      pend     <= '{tag: req_head.tag, rdata: ERR_DATA, rerror: 1'b1};
    end else if (pend_vld && !hw_push) begin
      pend_vld <= 1'b0;
    end
  end

  // Registered strobe to the register block; fields are zero when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.hwregs_request <= 1'b0;
      bus.hwregs_write   <= 1'b0;
      bus.hwregs_address <= '0;
      bus.hwregs_wmask   <= '0;
      bus.hwregs_wdata   <= '0;
    end else begin
      bus.hwregs_request <= issue_strobe;
      bus.hwregs_write   <= issue_strobe && req_head.write;
      bus.hwregs_address <= issue_strobe ? req_head.address[15:0] : 16'h0;
      bus.hwregs_wmask   <= (issue_strobe && req_head.write) ? req_head.wmask : 4'h0;
      if (!issue_strobe)       bus.hwregs_wdata <= '0;
      else if (req_head.write) bus.hwregs_wdata <= req_head.wdata;
      else                     bus.hwregs_wdata <= {23'b0, req_head.tag};
    end
  end

`ifndef SYNTHESIS
  logic spurious_seen;

  // Sticky record of register-block responses that arrived with no read outstanding.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) spurious_seen <= 1'b0;
    else       spurious_seen <= spurious_seen | (bus.hwregs_rvalid && (hw_out == '0));
  end

  // Credits reserve every response slot, so a push never meets a full queue without a pop.
  always_ff @(posedge clock) begin
    if (!reset) assert (!(rsp_push && rsp_full && !rsp_pop));
  end
`endif

endmodule

// File: tb/tb_hwregs_bridge.sv
module tb_hwregs_bridge;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hwregs_bridge_if bus();

  hwregs_bridge #(.REQ_DEPTH(4), .RSP_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   checks   = 0;
  int   errors   = 0;
  int   hw_reads = 0;
  logic inject_spur = 1'b0;

  // Register block model: answers each read one cycle after its strobe with {7'h0, tag, address}.
  always @(posedge clock) begin
    bus.hwregs_rvalid <= (bus.hwregs_request && !bus.hwregs_write) || inject_spur;
    bus.hwregs_rtag   <= bus.hwregs_wdata[8:0];
    bus.hwregs_rdata  <= {7'h0, bus.hwregs_wdata[8:0], bus.hwregs_address};
    if (bus.hwregs_request && !bus.hwregs_write) hw_reads <= hw_reads + 1;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, input logic [8:0] tag);
    int n;
    n = 0;
    bus.cpu_request = 1'b1;
    bus.cpu_write   = wr;
    bus.cpu_address = addr;
    bus.cpu_wmask   = mask;
    bus.cpu_wdata   = data;
    bus.cpu_tag     = tag;
    while (!bus.cpu_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", 64'(bus.cpu_ready), 64'd1);
    tick();
    bus.cpu_request = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          got;
    int          base;
    logic        seen_a;
    logic        seen_b;
    logic [8:0]  exp_t;
    logic [15:0] exp_a;

    bus.cpu_request = 1'b0;
    bus.cpu_write   = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_wmask   = '0;
    bus.cpu_wdata   = '0;
    bus.cpu_tag     = '0;
    bus.cpu_rready  = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_ready",   64'(bus.cpu_ready), 64'd0);
    chk("rst_rvalid",  64'(bus.cpu_rvalid), 64'd0);
    chk("rst_hwreq",   64'(bus.hwregs_request), 64'd0);
    chk("rst_rerror",  64'(bus.cpu_rerror), 64'd0);
    chk("rst_rdata",   64'(bus.cpu_rdata), 64'd0);
    chk("rst_rtag",    64'(bus.cpu_rtag), 64'd0);
    chk("rst_hwwdata", 64'(bus.hwregs_wdata), 64'd0);
    chk("rst_hwaddr",  64'(bus.hwregs_address), 64'd0);
    reset = 1'b0;
    #1;
    chk("rel_ready_low", 64'(bus.cpu_ready), 64'd0);
    tick();
    chk("rel_ready_high", 64'(bus.cpu_ready), 64'd1);

    // Valid read: strobe after 1 cycle, response after 3
    send(1'b0, 32'hE000_0008, 4'h0, 32'h0, 9'h005);
    chk("rd_strobe_early", 64'(bus.hwregs_request), 64'd0);
    tick();
    chk("rd_strobe",  64'(bus.hwregs_request), 64'd1);
    chk("rd_write",   64'(bus.hwregs_write), 64'd0);
    chk("rd_wdata",   64'(bus.hwregs_wdata), 64'h005);
    chk("rd_addr",    64'(bus.hwregs_address), 64'h0008);
    tick();
    chk("rd_strobe_1cyc", 64'(bus.hwregs_request), 64'd0);
    chk("rd_rvalid_early", 64'(bus.cpu_rvalid), 64'd0);
    tick();
    chk("rd_rvalid",  64'(bus.cpu_rvalid), 64'd1);
    chk("rd_rtag",    64'(bus.cpu_rtag), 64'h005);
    chk("rd_rdata",   64'(bus.cpu_rdata), 64'h0005_0008);
    chk("rd_rerror",  64'(bus.cpu_rerror), 64'd0);
    tick();
    chk("rd_popped",  64'(bus.cpu_rvalid), 64'd0);

    // Decode-error read: no strobe, error response after 2 cycles
    send(1'b0, 32'hD000_0000, 4'h0, 32'h0, 9'h1FF);
    tick();
    chk("err_no_strobe", 64'(bus.hwregs_request), 64'd0);
    chk("err_rvalid_early", 64'(bus.cpu_rvalid), 64'd0);
    tick();
    chk("err_rvalid", 64'(bus.cpu_rvalid), 64'd1);
    chk("err_rtag",   64'(bus.cpu_rtag), 64'h1FF);
    chk("err_rdata",  64'(bus.cpu_rdata), 64'hFFFF_FFFF);
    chk("err_rerror", 64'(bus.cpu_rerror), 64'd1);
    tick();

    // Misaligned write: silently dropped
    send(1'b1, 32'hE000_0001, 4'hF, 32'h1234_5678, 9'h0);
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen_a |= bus.hwregs_request;
      seen_b |= bus.cpu_rvalid;
      tick();
    end
    chk("badwr_no_strobe", 64'(seen_a), 64'd0);
    chk("badwr_no_rsp",    64'(seen_b), 64'd0);

    // Valid write: one-cycle strobe, no response
    send(1'b1, 32'hE000_0010, 4'h3, 32'hDEAD_BEEF, 9'h0);
    tick();
    chk("wr_strobe", 64'(bus.hwregs_request), 64'd1);
    chk("wr_write",  64'(bus.hwregs_write), 64'd1);
    chk("wr_addr",   64'(bus.hwregs_address), 64'h0010);
    chk("wr_wmask",  64'(bus.hwregs_wmask), 64'h3);
    chk("wr_wdata",  64'(bus.hwregs_wdata), 64'hDEAD_BEEF);
    seen_a = 1'b0;
    seen_b = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      seen_a |= bus.hwregs_request;
      seen_b |= bus.cpu_rvalid;
      tick();
    end
    chk("wr_strobe_once", 64'(seen_a), 64'd0);
    chk("wr_no_rsp",      64'(seen_b), 64'd0);

    // Spurious register response: dropped and flagged
    inject_spur = 1'b1;
    tick();
    inject_spur = 1'b0;
    seen_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_b |= bus.cpu_rvalid;
    end
    chk("spur_no_rsp", 64'(seen_b), 64'd0);
    chk("spur_flag",   64'(dut.spurious_seen), 64'd1);

    // Six reads with responses held off: four credits, queue fills
    bus.cpu_rready = 1'b0;
    base = hw_reads;
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 32'hE000_0000 + 32'(4 * i), 4'h0, 32'h0, 9'(9'h010 + 9'(i)));
    end
    send(1'b1, 32'hE000_0002, 4'hF, 32'h0, 9'h0);
    send(1'b1, 32'hE000_0006, 4'hF, 32'h0, 9'h0);
    chk("bp_ready_low", 64'(bus.cpu_ready), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_issued",   64'(hw_reads - base), 64'd4);
    chk("bp_rvalid",   64'(bus.cpu_rvalid), 64'd1);
    chk("bp_head_tag", 64'(bus.cpu_rtag), 64'h010);

    // Release responses: all six in tag order
    bus.cpu_rready = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 6; i++) begin
      if (bus.cpu_rvalid) begin
        exp_t = 9'h010 + 9'(got);
        exp_a = 16'(4 * got);
        chk("bp_tag",  64'(bus.cpu_rtag), 64'(exp_t));
        chk("bp_data", 64'(bus.cpu_rdata), 64'({7'h0, exp_t, exp_a}));
        got++;
      end
      tick();
    end
    chk("bp_count", 64'(got), 64'd6);
    tick();
    chk("bp_ready_back", 64'(bus.cpu_ready), 64'd1);

    // Error entry collides with a register response: register response first
    send(1'b0, 32'hE000_0020, 4'h0, 32'h0, 9'h021);
    send(1'b0, 32'hE000_0003, 4'h0, 32'h0, 9'h022);
    n = 0;
    while (!bus.cpu_rvalid && n < 10) begin
      tick();
      n++;
    end
    chk("coll_wait",    64'(n), 64'd2);
    chk("coll_first",   64'(bus.cpu_rtag), 64'h021);
    chk("coll_first_e", 64'(bus.cpu_rerror), 64'd0);
    tick();
    chk("coll_second_v", 64'(bus.cpu_rvalid), 64'd1);
    chk("coll_second",   64'(bus.cpu_rtag), 64'h022);
    chk("coll_second_e", 64'(bus.cpu_rerror), 64'd1);
    chk("coll_second_d", 64'(bus.cpu_rdata), 64'hFFFF_FFFF);
    tick();
    chk("coll_drained", 64'(bus.cpu_rvalid), 64'd0);

    // Reset with reads outstanding
    bus.cpu_rready = 1'b0;
    send(1'b0, 32'hE000_0040, 4'h0, 32'h0, 9'h031);
    send(1'b0, 32'hE000_0044, 4'h0, 32'h0, 9'h032);
    send(1'b0, 32'hE000_0048, 4'h0, 32'h0, 9'h033);
    tick();
    chk("mid_rvalid", 64'(bus.cpu_rvalid), 64'd1);
    chk("mid_hwreq",  64'(bus.hwregs_request), 64'd1);
    reset = 1'b1;
    #1;
    chk("mrst_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    chk("mrst_rtag",   64'(bus.cpu_rtag), 64'd0);
    chk("mrst_rdata",  64'(bus.cpu_rdata), 64'd0);
    chk("mrst_hwreq",  64'(bus.hwregs_request), 64'd0);
    chk("mrst_ready",  64'(bus.cpu_ready), 64'd0);
    chk("mrst_wdata",  64'(bus.hwregs_wdata), 64'd0);
    tick();
    tick();
    tick();
    reset = 1'b0;
    bus.cpu_rready = 1'b1;
    seen_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_b |= bus.cpu_rvalid;
    end
    chk("mrst_no_stale", 64'(seen_b), 64'd0);
    send(1'b0, 32'hE000_004C, 4'h0, 32'h0, 9'h055);
    n = 0;
    while (!bus.cpu_rvalid && n < 10) begin
      tick();
      n++;
    end
    chk("post_lat",  64'(n), 64'd3);
    chk("post_tag",  64'(bus.cpu_rtag), 64'h055);
    chk("post_data", 64'(bus.cpu_rdata), 64'h0055_004C);
    chk("post_err",  64'(bus.cpu_rerror), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
